iob_dma_desc_fetch: RTL and testbench
=====================================

IOB_DMA_DESC_FETCH -- requirements
Module: iob_dma_desc_fetch

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning the address width of the memory master and of the descriptor fields.
REQ-002 SHALL have parameter DATA_W, default 32, meaning the data width of all ports; only 32 is supported.
REQ-003 SHALL have parameter LEN_W, default 16, meaning the width of the transfer length field.
REQ-004 SHALL have port clk, input, 1, the single clock.
REQ-005 SHALL have port rst, input, 1, reset; reset is synchronous and active-high.
REQ-006 SHALL have ports s_valid/s_addr[1:0]/s_wdata[31:0]/s_wstrb[3:0], inputs, forming the control native slave request.
REQ-007 SHALL have ports s_rdata[31:0] and s_ready, outputs, forming the control slave response.
REQ-008 SHALL have ports m_valid and m_addr[ADDR_W-1:0], outputs, forming the descriptor-fetch native master request; m_wstrb[3:0] is an output tied to 0.
REQ-009 SHALL have ports m_rdata[31:0] and m_ready, inputs, forming the memory response.
REQ-010 SHALL have ports c_valid, c_addr[2:0], c_wdata[31:0] and c_wstrb[3:0], outputs, driving the DMA configuration slave port; c_wstrb is tied to 4'hF.
REQ-011 SHALL have port c_ready, input, 1, the DMA configuration acknowledge.
REQ-012 SHALL have port dma_done, input, 1, a one-cycle pulse when the DMA finishes a transfer.
REQ-013 SHALL have port irq, output, 1, a one-cycle pulse when the descriptor list completes or is aborted.

Function
REQ-014 SHALL define the control registers as: 0 LIST_BASE (RW); 1 CMD (W: bit0 start, bit1 abort; reads 0); 2 STATUS (R: bit0 busy, bit1 done, bit2 len_err, [15:8] descriptors completed).
REQ-015 SHALL assert s_ready exactly one cycle after each s_valid cycle, with s_rdata valid in that cycle; a write occurs only when s_wstrb != 0.
REQ-016 SHALL define a descriptor as 4 words at base+0/4/8/12: addr_a, addr_b, ctrl (bit31 direction, bit30 last, [LEN_W-1:0] length in bytes), and next pointer.
REQ-017 SHALL implement the FSM IDLE -> FETCH -> CFG -> WAIT_DONE -> (FETCH or IDLE).
REQ-018 SHALL, in IDLE, move to FETCH on a start write; it SHALL load the pointer from LIST_BASE and clear done, len_err and the descriptor count.
REQ-019 SHALL, in FETCH, issue 4 sequential reads at pointer+0, +4, +8 and +12; each holds m_valid and m_addr until m_ready, and m_valid drops in the cycle after m_ready.
REQ-020 SHALL, in CFG, write c_addr 0 (addr_a), 1 (addr_b), 2 (length), 3 (direction) and then 4 (value 1, the run command), each held until c_ready.
REQ-021 SHALL, when the fetched length is 0, skip CFG, set len_err, and treat the descriptor as last.
REQ-022 SHALL, in WAIT_DONE on dma_done, increment the count (saturating at 255); if last is set it SHALL go to IDLE, otherwise it SHALL load pointer=next and go to FETCH.
REQ-023 SHALL, on list completion, set done, clear busy, and pulse irq for one cycle.
REQ-024 SHALL ignore a start issued while busy; busy SHALL be high in every non-IDLE state.
REQ-025 SHALL latch an abort; an outstanding m_ or c_ handshake SHALL complete first, and then the block returns to IDLE, sets done and pulses irq; an abort in WAIT_DONE takes effect immediately.
REQ-026 SHALL ignore a dma_done outside WAIT_DONE.
REQ-027 SHALL wrap pointer arithmetic modulo 2^ADDR_W.

Reset
REQ-028 SHALL, on rst, set the state to IDLE, clear all registers, and drive m_valid, c_valid, s_ready and irq to 0.
REQ-029 SHALL, on rst mid-operation, drop valids in the next cycle and not complete the pending handshake.

Structure
REQ-030 SHALL place the control register offsets, descriptor word offsets, ctrl bit positions and DMA config addresses 0-4 in a shared package/header.
REQ-031 SHALL implement the control register file as the sub-module iob_dma_desc_regs.

Verification
REQ-032 SHALL verify a single descriptor {0x100, 0x200, ctrl=0x40000010, x} -> reads at base..base+12 -> config writes (0,0x100), (1,0x200), (2,0x10), (3,0), (4,1) -> dma_done -> irq, STATUS=0x0102.
REQ-033 SHALL verify a 2-descriptor chain with next=0x80 -> the second fetch starts at 0x80 -> two run writes -> STATUS[15:8]=2.
REQ-034 SHALL verify m_ready delayed by 5 cycles -> m_addr stable throughout and no duplicate request.
REQ-035 SHALL verify length=0 -> no c_valid asserted -> len_err=1, irq asserted.
REQ-036 SHALL verify abort during CFG with c_ready withheld -> c_valid held until c_ready, then IDLE and irq.
REQ-037 SHALL verify a second start while busy, and rst in FETCH -> the second start is ignored; after rst, m_valid=0 and STATUS=0.

Source files
------------

// File: rtl/iob_dma_desc_fetch_pkg.sv
// Shared constants for the DMA descriptor fetcher: control register map,
// descriptor layout, ctrl word bit positions and DMA config addresses.
package iob_dma_desc_fetch_pkg;

  localparam logic [1:0] REG_LIST_BASE = 2'd0;
  localparam logic [1:0] REG_CMD       = 2'd1;
  localparam logic [1:0] REG_STATUS    = 2'd2;

  localparam int CMD_START_BIT = 0;
  localparam int CMD_ABORT_BIT = 1;

  // Descriptor word indices; the byte offset of a word is its index times 4
  localparam logic [1:0] DESC_ADDR_A = 2'd0;
  localparam logic [1:0] DESC_ADDR_B = 2'd1;
  localparam logic [1:0] DESC_CTRL   = 2'd2;
  localparam logic [1:0] DESC_NEXT   = 2'd3;
  localparam logic [2:0] DESC_WORDS  = 3'd4;

  localparam int CTRL_DIR_BIT  = 31;
  localparam int CTRL_LAST_BIT = 30;

  localparam logic [2:0] CFG_ADDR_A = 3'd0;
  localparam logic [2:0] CFG_ADDR_B = 3'd1;
  localparam logic [2:0] CFG_LEN    = 3'd2;
  localparam logic [2:0] CFG_DIR    = 3'd3;
  localparam logic [2:0] CFG_RUN    = 3'd4;
  localparam logic [2:0] CFG_END    = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_CFG,
    ST_WAIT_DONE
  } state_e;

endpackage

// File: rtl/iob_dma_desc_regs.sv
// Control register file: LIST_BASE storage, CMD strobes and STATUS readback
// behind a native slave port with a fixed one-cycle response.
module iob_dma_desc_regs
  import iob_dma_desc_fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        s_valid,
  input  logic [1:0]  s_addr,
  input  logic [31:0] s_wdata,
  input  logic [3:0]  s_wstrb,
  output logic [31:0] s_rdata,
  output logic        s_ready,
  input  logic        busy_i,
  input  logic        done_i,
  input  logic        lenErr_i,
  input  logic [7:0]  descCnt_i,
  output logic [31:0] listBase_o,
  output logic        start_o,
  output logic        abort_o
);

  logic [31:0] listBase_q;
  logic [31:0] rdata_q;
  logic [31:0] rdata_d;
  logic        ready_q;
  logic        wrEn;

  assign wrEn    = s_valid && (s_wstrb != 4'b0000);
  assign start_o = wrEn && (s_addr == REG_CMD) && s_wstrb[0] && s_wdata[CMD_START_BIT];
  assign abort_o = wrEn && (s_addr == REG_CMD) && s_wstrb[0] && s_wdata[CMD_ABORT_BIT];

  always_comb begin
    rdata_d = '0;
    case (s_addr)
      REG_LIST_BASE: rdata_d = listBase_q;
      REG_STATUS:    rdata_d = {16'b0, descCnt_i, 5'b0, lenErr_i, done_i, busy_i};
      default:       rdata_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      listBase_q <= '0;
      rdata_q    <= '0;
      ready_q    <= 1'b0;
    end else begin
      ready_q <= s_valid;
      rdata_q <= rdata_d;
      if (wrEn && (s_addr == REG_LIST_BASE)) begin
        for (int b = 0; b < 4; b++) begin
          if (s_wstrb[b]) listBase_q[8*b +: 8] <= s_wdata[8*b +: 8];
        end
      end
    end
  end

  assign s_rdata    = rdata_q;
  assign s_ready    = ready_q;
  assign listBase_o = listBase_q;

endmodule

// File: rtl/iob_dma_desc_fetch.sv
// Walks a linked list of 4-word DMA descriptors in memory, programs the DMA
// for each one and waits for its completion before following the next pointer.
module iob_dma_desc_fetch
  import iob_dma_desc_fetch_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  input  logic [1:0]        s_addr,
  input  logic [DATA_W-1:0] s_wdata,
  input  logic [3:0]        s_wstrb,
  output logic [DATA_W-1:0] s_rdata,
  output logic              s_ready,
  output logic              m_valid,
  output logic [ADDR_W-1:0] m_addr,
  output logic [3:0]        m_wstrb,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_ready,
  output logic              c_valid,
  output logic [2:0]        c_addr,
  output logic [DATA_W-1:0] c_wdata,
  output logic [3:0]        c_wstrb,
  input  logic              c_ready,
  input  logic              dma_done,
  output logic              irq
);

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  ptr_q, ptr_d;
  logic [ADDR_W-1:0]  addrA_q, addrA_d;
  logic [ADDR_W-1:0]  addrB_q, addrB_d;
  logic [ADDR_W-1:0]  next_q, next_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               dir_q, dir_d;
  logic               last_q, last_d;
  logic [2:0]         wordIdx_q, wordIdx_d;
  logic [2:0]         cfgIdx_q, cfgIdx_d;
  logic               mValid_q, mValid_d;
  logic               cValid_q, cValid_d;
  logic               abort_q, abort_d;
  logic               done_q, done_d;
  logic               lenErr_q, lenErr_d;
  logic [7:0]         cnt_q, cnt_d;
  logic               irq_q, irq_d;

  logic [31:0]        listBase;
  logic               startPulse;
  logic               abortPulse;
  logic               abortAny;
  logic               finish;
  logic               busy;

  assign busy = (state_q != ST_IDLE);

  iob_dma_desc_regs u_regs (
    .clk        (clk),
    .rst        (rst),
    .s_valid    (s_valid),
    .s_addr     (s_addr),
    .s_wdata    (s_wdata),
    .s_wstrb    (s_wstrb),
    .s_rdata    (s_rdata),
    .s_ready    (s_ready),
    .busy_i     (busy),
    .done_i     (done_q),
    .lenErr_i   (lenErr_q),
    .descCnt_i  (cnt_q),
    .listBase_o (listBase),
    .start_o    (startPulse),
    .abort_o    (abortPulse)
  );

  // Valids drop for one cycle after every handshake; a pending abort is only
  // honoured in those gaps so no bus transaction is ever cut short.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    addrA_d   = addrA_q;
    addrB_d   = addrB_q;
    next_d    = next_q;
    len_d     = len_q;
    dir_d     = dir_q;
    last_d    = last_q;
    wordIdx_d = wordIdx_q;
    cfgIdx_d  = cfgIdx_q;
    mValid_d  = mValid_q;
    cValid_d  = cValid_q;
    abort_d   = abort_q;
    done_d    = done_q;
    lenErr_d  = lenErr_q;
    cnt_d     = cnt_q;
    irq_d     = 1'b0;
    finish    = 1'b0;
    abortAny  = abort_q | abortPulse;

    unique case (state_q)
      ST_IDLE: begin
        if (startPulse) begin
          state_d   = ST_FETCH;
          ptr_d     = listBase[ADDR_W-1:0];
          wordIdx_d = '0;
          done_d    = 1'b0;
          lenErr_d  = 1'b0;
          cnt_d     = '0;
          abort_d   = 1'b0;
        end
      end
      ST_FETCH: begin
        if (abortPulse) abort_d = 1'b1;
        if (mValid_q) begin
          if (m_ready) begin
            mValid_d  = 1'b0;
            wordIdx_d = wordIdx_q + 3'd1;
            unique case (wordIdx_q[1:0])
              DESC_ADDR_A: addrA_d = m_rdata[ADDR_W-1:0];
              DESC_ADDR_B: addrB_d = m_rdata[ADDR_W-1:0];
              DESC_CTRL: begin
                len_d  = m_rdata[LEN_W-1:0];
                dir_d  = m_rdata[CTRL_DIR_BIT];
                last_d = m_rdata[CTRL_LAST_BIT];
              end
              DESC_NEXT:   next_d = m_rdata[ADDR_W-1:0];
            endcase
          end
        end else if (abortAny) begin
          finish = 1'b1;
        end else if (wordIdx_q == DESC_WORDS) begin
          // A zero-length descriptor cannot be run, so it ends the list
          if (len_q == '0) begin
            lenErr_d = 1'b1;
            finish   = 1'b1;
          end else begin
            state_d  = ST_CFG;
            cfgIdx_d = CFG_ADDR_A;
          end
        end else begin
          mValid_d = 1'b1;
        end
      end
      ST_CFG: begin
        if (abortPulse) abort_d = 1'b1;
        if (cValid_q) begin
          if (c_ready) begin
            cValid_d = 1'b0;
            cfgIdx_d = cfgIdx_q + 3'd1;
          end
        end else if (abortAny) begin
          finish = 1'b1;
        end else if (cfgIdx_q == CFG_END) begin
          state_d = ST_WAIT_DONE;
        end else begin
          cValid_d = 1'b1;
        end
      end
      ST_WAIT_DONE: begin
        if (abortAny) begin
          finish = 1'b1;
        end else if (dma_done) begin
          if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
          if (last_q) begin
            finish = 1'b1;
          end else begin
            ptr_d     = next_q;
            wordIdx_d = '0;
            state_d   = ST_FETCH;
          end
        end
      end
    endcase

    if (finish) begin
      state_d = ST_IDLE;
      done_d  = 1'b1;
      irq_d   = 1'b1;
      abort_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      addrA_q   <= '0;
      addrB_q   <= '0;
      next_q    <= '0;
      len_q     <= '0;
      dir_q     <= 1'b0;
      last_q    <= 1'b0;
      wordIdx_q <= '0;
      cfgIdx_q  <= '0;
      mValid_q  <= 1'b0;
      cValid_q  <= 1'b0;
      abort_q   <= 1'b0;
      done_q    <= 1'b0;
      lenErr_q  <= 1'b0;
      cnt_q     <= '0;
      irq_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      addrA_q   <= addrA_d;
      addrB_q   <= addrB_d;
      next_q    <= next_d;
      len_q     <= len_d;
      dir_q     <= dir_d;
      last_q    <= last_d;
      wordIdx_q <= wordIdx_d;
      cfgIdx_q  <= cfgIdx_d;
      mValid_q  <= mValid_d;
      cValid_q  <= cValid_d;
      abort_q   <= abort_d;
      done_q    <= done_d;
      lenErr_q  <= lenErr_d;
      cnt_q     <= cnt_d;
      irq_q     <= irq_d;
    end
  end

  always_comb begin
    c_wdata = '0;
    case (cfgIdx_q)
      CFG_ADDR_A: c_wdata = DATA_W'(addrA_q);
      CFG_ADDR_B: c_wdata = DATA_W'(addrB_q);
      CFG_LEN:    c_wdata = DATA_W'(len_q);
      CFG_DIR:    c_wdata = DATA_W'(dir_q);
      CFG_RUN:    c_wdata = DATA_W'(1);
      default:    c_wdata = '0;
    endcase
  end

  assign m_valid = mValid_q;
  assign m_addr  = ptr_q + ADDR_W'({wordIdx_q[1:0], 2'b00});
  assign m_wstrb = 4'h0;
  assign c_valid = cValid_q;
  assign c_addr  = cfgIdx_q;
  assign c_wstrb = 4'hF;
  assign irq     = irq_q;

endmodule

// File: tb/tb_iob_dma_desc_fetch.sv
// Directed bench for iob_dma_desc_fetch with a memory model, a DMA config
// responder that auto-completes runs, and a single checking task.
module tb_iob_dma_desc_fetch;

  logic        clk;
  logic        rst;
  logic        s_valid;
  logic [1:0]  s_addr;
  logic [31:0] s_wdata;
  logic [3:0]  s_wstrb;
  logic [31:0] s_rdata;
  logic        s_ready;
  logic        m_valid;
  logic [31:0] m_addr;
  logic [3:0]  m_wstrb;
  logic [31:0] m_rdata;
  logic        m_ready;
  logic        c_valid;
  logic [2:0]  c_addr;
  logic [31:0] c_wdata;
  logic [3:0]  c_wstrb;
  logic        c_ready;
  logic        dma_done;
  logic        irq;

  logic [31:0] mem [0:255];
  logic [31:0] mLog [$];
  logic [34:0] cLog [$];
  int          mDelay;
  int          mWaitCnt;
  logic [31:0] heldAddr;
  int          stabErr;
  logic        cHold;
  int          doneCnt;
  int          irqCount;
  logic        cValidSeen;
  int          checkCount;
  int          errCount;

  iob_dma_desc_fetch dut (
    .clk      (clk),
    .rst      (rst),
    .s_valid  (s_valid),
    .s_addr   (s_addr),
    .s_wdata  (s_wdata),
    .s_wstrb  (s_wstrb),
    .s_rdata  (s_rdata),
    .s_ready  (s_ready),
    .m_valid  (m_valid),
    .m_addr   (m_addr),
    .m_wstrb  (m_wstrb),
    .m_rdata  (m_rdata),
    .m_ready  (m_ready),
    .c_valid  (c_valid),
    .c_addr   (c_addr),
    .c_wdata  (c_wdata),
    .c_wstrb  (c_wstrb),
    .c_ready  (c_ready),
    .dma_done (dma_done),
    .irq      (irq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  function automatic logic [34:0] cfgEnt(input logic [2:0] a, input logic [31:0] d);
    return {a, d};
  endfunction

  // Memory responder: acks each request after mDelay cycles and records it
  initial begin
    m_ready  = 1'b0;
    m_rdata  = '0;
    mWaitCnt = 0;
    heldAddr = '0;
    forever begin
      tick();
      m_ready = 1'b0;
      if (m_valid) begin
        if (mWaitCnt == 0) heldAddr = m_addr;
        else if (m_addr != heldAddr) stabErr++;
        if (mWaitCnt >= mDelay) begin
          m_ready  = 1'b1;
          m_rdata  = mem[m_addr[9:2]];
          mLog.push_back(m_addr);
          mWaitCnt = 0;
        end else begin
          mWaitCnt++;
        end
      end else begin
        mWaitCnt = 0;
      end
    end
  end

  // DMA config responder: logs writes and raises dma_done 3 cycles after a run
  initial begin
    c_ready  = 1'b0;
    dma_done = 1'b0;
    doneCnt  = 0;
    forever begin
      tick();
      c_ready  = 1'b0;
      dma_done = 1'b0;
      if (doneCnt > 0) begin
        doneCnt--;
        if (doneCnt == 0) dma_done = 1'b1;
      end
      if (c_valid && !cHold) begin
        c_ready = 1'b1;
        cLog.push_back(cfgEnt(c_addr, c_wdata));
        if (c_addr == 3'd4) doneCnt = 3;
      end
    end
  end

  initial begin
    irqCount   = 0;
    cValidSeen = 1'b0;
    forever begin
      @(negedge clk);
      if (irq) irqCount++;
      if (c_valid) cValidSeen = 1'b1;
    end
  end

  task automatic busWrite(input logic [1:0] addr, input logic [31:0] data);
    s_valid = 1'b1;
    s_addr  = addr;
    s_wdata = data;
    s_wstrb = 4'hF;
    tick();
    s_valid = 1'b0;
    s_wstrb = 4'h0;
  endtask

  task automatic busRead(input logic [1:0] addr, output logic [31:0] data);
    s_valid = 1'b1;
    s_addr  = addr;
    s_wstrb = 4'h0;
    tick();
    s_valid = 1'b0;
    checkOutput("s_ready", 64'(s_ready), 64'(1));
    data = s_rdata;
  endtask

  task automatic applyStimulus(input logic [31:0] base);
    mLog.delete();
    cLog.delete();
    busWrite(2'd0, base);
    busWrite(2'd1, 32'h1);
  endtask

  task automatic loadDesc(input logic [31:0] base, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ctrl, input logic [31:0] nxt);
    mem[base[9:2]]        = a;
    mem[base[9:2] + 8'd1] = b;
    mem[base[9:2] + 8'd2] = ctrl;
    mem[base[9:2] + 8'd3] = nxt;
  endtask

  task automatic waitIrq(input int prev, input string tag);
    int n = 0;
    while (irqCount == prev && n < 500) begin
      tick();
      n++;
    end
    checkOutput(tag, 64'(irqCount - prev), 64'(1));
  endtask

  task automatic waitSignal(input logic isM, input string tag);
    int n = 0;
    while (((isM && !m_valid) || (!isM && !c_valid)) && n < 200) begin
      tick();
      n++;
    end
    checkOutput(tag, 64'(n < 200), 64'(1));
  endtask

  logic [31:0] rd;
  logic [34:0] expCfg [10];
  int          prevIrq;
  int          runs;

  initial begin
    checkCount = 0;
    errCount   = 0;
    stabErr    = 0;
    mDelay     = 0;
    cHold      = 1'b0;
    rst        = 1'b1;
    s_valid    = 1'b0;
    s_addr     = '0;
    s_wdata    = '0;
    s_wstrb    = '0;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    loadDesc(32'h40,  32'h100, 32'h200, 32'h4000_0010, 32'hDEAD_BEEF);
    loadDesc(32'h200, 32'h300, 32'h310, 32'h0000_0020, 32'h80);
    loadDesc(32'h80,  32'h120, 32'h130, 32'hC000_0008, 32'h0);
    loadDesc(32'h180, 32'h1,   32'h2,   32'h4000_0000, 32'h0);

    repeat (3) tick();
    checkOutput("rst_m_valid", 64'(m_valid), 64'(0));
    checkOutput("rst_c_valid", 64'(c_valid), 64'(0));
    checkOutput("rst_s_ready", 64'(s_ready), 64'(0));
    checkOutput("rst_irq", 64'(irq), 64'(0));
    checkOutput("m_wstrb", 64'(m_wstrb), 64'(0));
    checkOutput("c_wstrb", 64'(c_wstrb), 64'(4'hF));
    rst = 1'b0;
    tick();
    busRead(2'd2, rd);
    checkOutput("rst_status", 64'(rd), 64'(0));

    // Single descriptor
    prevIrq = irqCount;
    applyStimulus(32'h40);
    busRead(2'd0, rd);
    checkOutput("list_base", 64'(rd), 64'(32'h40));
    waitIrq(prevIrq, "single_irq");
    checkOutput("single_nreads", 64'(mLog.size()), 64'(4));
    for (int i = 0; i < 4; i++)
      checkOutput($sformatf("single_raddr%0d", i),
                  64'((i < mLog.size()) ? mLog[i] : 32'hFFFF_FFFF), 64'(32'h40 + 4 * i));
    expCfg[0] = cfgEnt(3'd0, 32'h100);
    expCfg[1] = cfgEnt(3'd1, 32'h200);
    expCfg[2] = cfgEnt(3'd2, 32'h10);
    expCfg[3] = cfgEnt(3'd3, 32'h0);
    expCfg[4] = cfgEnt(3'd4, 32'h1);
    checkOutput("single_ncfg", 64'(cLog.size()), 64'(5));
    for (int i = 0; i < 5; i++)
      checkOutput($sformatf("single_cfg%0d", i),
                  64'((i < cLog.size()) ? cLog[i] : '1), 64'(expCfg[i]));
    busRead(2'd2, rd);
    checkOutput("single_status", 64'(rd), 64'(32'h0102));

    // Two-descriptor chain
    prevIrq = irqCount;
    applyStimulus(32'h200);
    waitIrq(prevIrq, "chain_irq");
    checkOutput("chain_nreads", 64'(mLog.size()), 64'(8));
    checkOutput("chain_second_fetch", 64'((mLog.size() > 4) ? mLog[4] : 32'hFFFF_FFFF), 64'(32'h80));
    expCfg[0] = cfgEnt(3'd0, 32'h300);
    expCfg[1] = cfgEnt(3'd1, 32'h310);
    expCfg[2] = cfgEnt(3'd2, 32'h20);
    expCfg[3] = cfgEnt(3'd3, 32'h0);
    expCfg[4] = cfgEnt(3'd4, 32'h1);
    expCfg[5] = cfgEnt(3'd0, 32'h120);
    expCfg[6] = cfgEnt(3'd1, 32'h130);
    expCfg[7] = cfgEnt(3'd2, 32'h8);
    expCfg[8] = cfgEnt(3'd3, 32'h1);
    expCfg[9] = cfgEnt(3'd4, 32'h1);
    checkOutput("chain_ncfg", 64'(cLog.size()), 64'(10));
    runs = 0;
    for (int i = 0; i < cLog.size(); i++) if (cLog[i][34:32] == 3'd4) runs++;
    checkOutput("chain_runs", 64'(runs), 64'(2));
    for (int i = 0; i < 10; i++)
      checkOutput($sformatf("chain_cfg%0d", i),
                  64'((i < cLog.size()) ? cLog[i] : '1), 64'(expCfg[i]));
    busRead(2'd2, rd);
    checkOutput("chain_status", 64'(rd), 64'(32'h0202));

    // Slow memory: request held stable, no duplicates
    mDelay  = 5;
    stabErr = 0;
    prevIrq = irqCount;
    applyStimulus(32'h40);
    waitIrq(prevIrq, "slow_irq");
    checkOutput("slow_addr_stable", 64'(stabErr), 64'(0));
    checkOutput("slow_nreads", 64'(mLog.size()), 64'(4));
    checkOutput("slow_ncfg", 64'(cLog.size()), 64'(5));
    mDelay = 0;

    // Zero length
    prevIrq    = irqCount;
    cValidSeen = 1'b0;
    applyStimulus(32'h180);
    waitIrq(prevIrq, "len0_irq");
    checkOutput("len0_no_c_valid", 64'(cValidSeen), 64'(0));
    busRead(2'd2, rd);
    checkOutput("len0_status", 64'(rd), 64'(32'h0006));

    // Abort during CFG with c_ready withheld
    cHold   = 1'b1;
    prevIrq = irqCount;
    applyStimulus(32'h40);
    waitSignal(1'b0, "abort_c_valid_seen");
    busWrite(2'd1, 32'h2);
    repeat (5) tick();
    checkOutput("abort_c_valid_held", 64'(c_valid), 64'(1));
    checkOutput("abort_no_early_irq", 64'(irqCount - prevIrq), 64'(0));
    cHold = 1'b0;
    waitIrq(prevIrq, "abort_irq");
    checkOutput("abort_ncfg", 64'(cLog.size()), 64'(1));
    checkOutput("abort_cfg0", 64'((cLog.size() > 0) ? cLog[0] : '1), 64'(cfgEnt(3'd0, 32'h100)));
    checkOutput("abort_c_valid_low", 64'(c_valid), 64'(0));
    busRead(2'd2, rd);
    checkOutput("abort_status", 64'(rd), 64'(32'h0002));

    // Second start while busy, then reset during FETCH
    mDelay  = 20;
    prevIrq = irqCount;
    applyStimulus(32'h40);
    waitSignal(1'b1, "busy_m_valid_seen");
    checkOutput("busy_m_addr", 64'(m_addr), 64'(32'h40));
    busWrite(2'd0, 32'h200);
    busWrite(2'd1, 32'h1);
    tick();
    checkOutput("restart_ignored_addr", 64'(m_addr), 64'(32'h40));
    checkOutput("restart_ignored_valid", 64'(m_valid), 64'(1));
    busRead(2'd2, rd);
    checkOutput("busy_status", 64'(rd), 64'(32'h0001));
    rst = 1'b1;
    tick();
    checkOutput("rst_mid_m_valid", 64'(m_valid), 64'(0));
    rst = 1'b0;
    tick();
    busRead(2'd2, rd);
    checkOutput("rst_mid_status", 64'(rd), 64'(0));
    busRead(2'd0, rd);
    checkOutput("rst_mid_list_base", 64'(rd), 64'(0));
    checkOutput("rst_mid_no_read", 64'(mLog.size()), 64'(0));
    checkOutput("rst_mid_no_irq", 64'(irqCount - prevIrq), 64'(0));
    mDelay = 0;

    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
